// File: rtl/slow_domain_feeder_pkg.sv
// rtl/slow_domain_feeder_pkg.sv - shared defaults and FSM state encoding for the slow-domain feeder
package slow_domain_feeder_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_DONE    = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/slow_domain_feeder_if.sv
// rtl/slow_domain_feeder_if.sv - fast-side write and slow-side present handshakes of the feeder
interface slow_domain_feeder_if
  import slow_domain_feeder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

endinterface

// File: rtl/slow_domain_feeder_sync_fifo.sv
// rtl/slow_domain_feeder_sync_fifo.sv - single-clock FIFO with occupancy count and synchronous flush
module slow_domain_feeder_sync_fifo
  import slow_domain_feeder_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [AW:0]       level,
  output logic              full
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Flush wins over both ports; full/empty come from level so the pointers may wrap freely.
  assign full     = (level == FULL_LVL);
  assign do_push  = push & ~flush & ~full;
  assign do_pop   = pop & ~flush & (level != '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/slow_domain_feeder.sv
// rtl/slow_domain_feeder.sv - buffers fast-domain words and presents one per slow_clk cycle,
// updating the output only right after a slow falling edge so it is stable at every slow rise.
module slow_domain_feeder
  import slow_domain_feeder_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 slow_clk,
  input  logic                 flush,
  slow_domain_feeder_if.slave  bus,
  output logic [AW:0]          level,
  output logic [15:0]          delivered
);

  feeder_state_e     state_q, state_d;
  logic              slow_q;
  logic              rdy_lat;
  logic              rise, fall;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q;
  logic [DATA_W-1:0] fifo_rd;
  logic              fifo_full;
  logic              pop;
  logic              xfer;

  assign rise = slow_clk & ~slow_q;
  assign fall = ~slow_clk & slow_q;

  assign bus.s_ready = ~fifo_full;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;

  slow_domain_feeder_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (bus.s_valid),
    .push_data (bus.s_data),
    .pop       (pop),
    .pop_data  (fifo_rd),
    .level     (level),
    .full      (fifo_full)
  );

  // m_ready is only trusted from the low phase, before slow logic reacts to the rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slow_q  <= 1'b0;
      rdy_lat <= 1'b0;
    end else begin
      slow_q <= slow_clk;
      if (!slow_clk) rdy_lat <= bus.m_ready;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid_q;
    pop       = 1'b0;
    xfer      = 1'b0;
    if (flush) begin
      state_d   = ST_IDLE;
      m_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fall && level != '0) begin
            pop       = 1'b1;
            m_valid_d = 1'b1;
            state_d   = ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (rise && rdy_lat) begin
            xfer    = 1'b1;
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (fall) begin
            if (level != '0) begin
              pop     = 1'b1;
              state_d = ST_PRESENT;
            end else begin
              m_valid_d = 1'b0;
              state_d   = ST_IDLE;
            end
          end
        end
        default: begin
          state_d   = ST_IDLE;
          m_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      delivered <= '0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      if (pop)  m_data_q  <= fifo_rd;
      if (xfer) delivered <= delivered + 16'd1;
    end
  end

endmodule
